// File: rtl/bram_port_arbiter_if.sv
// Requester, clear-control and single-port BRAM signals shared by the arbiter and its environment.
// slave is the arbiter's view; master is the requester/memory side.
interface bram_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              clr;
    logic              req_a;
    logic              req_b;
    logic              we_a;
    logic              we_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] din_a;
    logic [DATA_W-1:0] din_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              rvalid_a;
    logic              rvalid_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  clr, req_a, req_b, we_a, we_b, addr_a, addr_b, din_a, din_b, mem_dout,
        output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, busy,
        mem_addr, mem_we, mem_din
    );

    modport master (
        output clr, req_a, req_b, we_a, we_b, addr_a, addr_b, din_a, din_b, mem_dout,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, busy,
        mem_addr, mem_we, mem_din
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port BRAM, with a
// full-memory zero clear after reset and on every clr pulse.
module bram_port_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input logic               clk,
    input logic               rst,
    bram_port_arbiter_if.slave bus
);
    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [ADDR_W:0] CLR_LAST = {1'b0, {ADDR_W{1'b1}}};

    state_t            state;
    logic [ADDR_W:0]   clr_cnt;
    logic              last_b;
    logic              rvalid_a_q;
    logic              rvalid_b_q;
    logic              arb_en;
    logic              grant_a;
    logic              grant_b;
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [DATA_W-1:0] m_din;

    // clr beats any request in the same cycle; reset is synchronous, so gate
    // the grant path with rst directly to keep outputs quiet while it is held.
    always_comb begin
        arb_en  = (state == RUN) && !rst && !bus.clr;
        grant_a = arb_en && bus.req_a && (!bus.req_b || last_b);
        grant_b = arb_en && bus.req_b && (!bus.req_a || !last_b);
    end

    always_comb begin
        m_addr = '0;
        m_we   = 1'b0;
        m_din  = '0;
        if (!rst && state == CLEAR) begin
            m_addr = clr_cnt[ADDR_W-1:0];
            m_we   = 1'b1;
        end else if (grant_a) begin
            m_addr = bus.addr_a;
            m_we   = bus.we_a;
            m_din  = bus.din_a;
        end else if (grant_b) begin
            m_addr = bus.addr_b;
            m_we   = bus.we_b;
            m_din  = bus.din_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            last_b     <= 1'b1;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            rvalid_a_q <= grant_a && !bus.we_a;
            rvalid_b_q <= grant_b && !bus.we_b;
            if (grant_a)
                last_b <= 1'b0;
            else if (grant_b)
                last_b <= 1'b1;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST)
                        state <= RUN;
                end
                RUN: begin
                    if (bus.clr) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign bus.gnt_a    = grant_a;
    assign bus.gnt_b    = grant_b;
    assign bus.busy     = rst || (state == CLEAR);
    assign bus.rvalid_a = rvalid_a_q && !rst;
    assign bus.rvalid_b = rvalid_b_q && !rst;
    assign bus.rdata_a  = bus.mem_dout;
    assign bus.rdata_b  = bus.mem_dout;
    assign bus.mem_addr = m_addr;
    assign bus.mem_we   = m_we;
    assign bus.mem_din  = m_din;
endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning the shared memory address width (2048 words).
REQ-002 SHALL have parameter DATA_W, default 16, meaning the memory word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have port clr, input, 1, a pulse that requests a full-memory clear.
REQ-006 SHALL have ports req_a/req_b, input, 1, the access requests from requester A and requester B.
REQ-007 SHALL have ports we_a/we_b, input, 1, the write enable (1 = write, 0 = read) for each requester.
REQ-008 SHALL have ports addr_a/addr_b, input, ADDR_W, the access address for each requester.
REQ-009 SHALL have ports din_a/din_b, input, DATA_W, the write data for each requester.
REQ-010 SHALL have ports gnt_a/gnt_b, output, 1, the combinational grant; the access is issued in the cycle the grant is high.
REQ-011 SHALL have ports rvalid_a/rvalid_b, output, 1, a registered read-data-valid flag for each requester.
REQ-012 SHALL have ports rdata_a/rdata_b, output, DATA_W, the read data for each requester.
REQ-013 SHALL have port busy, output, 1, which is high while a clear is in progress.
REQ-014 SHALL have ports mem_addr (output, ADDR_W), mem_we (output, 1), mem_din (output, DATA_W) and mem_dout (input, DATA_W), which form the single-port BRAM interface; the BRAM has 1-cycle read latency and read-first behaviour.

Function
REQ-015 SHALL implement the FSM states CLEAR and RUN; after reset the state SHALL be CLEAR with the clear counter at 0.
REQ-016 In CLEAR, each cycle SHALL drive mem_we=1, mem_din=0 and mem_addr=counter, then increment the counter. After the write to address 2^ADDR_W-1 the FSM SHALL go to RUN; the clear therefore takes exactly 2048 cycles.
REQ-017 busy SHALL be 1 in CLEAR and 0 in RUN, and gnt_a and gnt_b SHALL both be 0 in CLEAR.
REQ-018 In RUN with exactly one req high, that requester SHALL be granted in the same cycle.
REQ-019 In RUN with both req high, the requester not granted last SHALL be granted (round-robin).
REQ-020 After reset the last-granted register SHALL be B, so A wins the first contention.
REQ-021 At most one gnt SHALL be high in any cycle.
REQ-022 In a granted cycle, mem_addr, mem_we and mem_din SHALL equal the winner's addr, we and din.
REQ-023 With no grant, mem_we SHALL be 0; mem_addr and mem_din are don't-care.
REQ-024 A requester SHALL hold req, we, addr and din stable until its gnt is seen. req may then drop, or stay high for back-to-back accesses; a single requester SHALL receive one grant per cycle.
REQ-025 A granted read SHALL produce rvalid_x=1 for exactly one cycle, in the cycle after the grant, with rdata_x = mem_dout in that cycle.
REQ-026 rdata_x is don't-care when rvalid_x=0.
REQ-027 A granted write SHALL produce no rvalid.
REQ-028 Read-after-write to the same address in consecutive cycles SHALL return the new data.
REQ-029 A clr pulse in RUN SHALL enter CLEAR on the next cycle with the counter at 0. If clr and one or more req coincide, clr SHALL win and no grant SHALL be given in that cycle.
REQ-030 A read granted in the cycle before clr takes effect SHALL still deliver its rvalid.
REQ-031 clr asserted while already in CLEAR SHALL be ignored; the clear in progress is not restarted.
REQ-032 The clear counter SHALL be ADDR_W+1 bits or use an explicit terminal compare; it SHALL NOT rely on wrap-around to detect completion.

Reset
REQ-033 While rst=1: gnt_a=gnt_b=0, rvalid_a=rvalid_b=0, mem_we=0, busy=1, state=CLEAR, counter=0, last-grant=B.
REQ-034 rst asserted mid-clear or mid-read SHALL abort the operation; a pending rvalid SHALL be dropped, and the clear SHALL restart at address 0 on the first cycle after rst falls.

Verification
REQ-035 Release rst -> busy=1 for 2048 cycles; mem_we=1 with mem_addr stepping 0..2047; busy=0 on cycle 2048; a read of any address then returns 0x0000.
REQ-036 After the clear, A writes 0x1234 to 0x005, then reads 0x005 -> rvalid_a high exactly one cycle after the read grant, rdata_a=0x1234, and rvalid_b stays 0.
REQ-037 Both requesters hold req with reads for 6 cycles -> grants alternate A,B,A,B,A,B, and each rvalid follows its own grant by one cycle.
REQ-038 B alone holds req for 4 cycles -> gnt_b high for 4 consecutive cycles, and gnt_a stays 0.
REQ-039 clr in the same cycle as req_a -> gnt_a=0 that cycle; busy rises next cycle; 2048 clear cycles follow; a read of 0x005 then returns 0x0000.
REQ-040 rst at clear cycle 1000 -> the clear restarts at address 0 and still takes 2048 cycles after rst falls.
